// File: rtl/muldiv_pkg.sv
// Shared RV32M definitions for the iterative multiply/divide unit and the
// funct7=0000001 decoder path: funct3 codes, FSM encoding, negate helper.
package muldiv_pkg;

    localparam logic [2:0] FUNC_MUL    = 3'd0;
    localparam logic [2:0] FUNC_MULH   = 3'd1;
    localparam logic [2:0] FUNC_MULHSU = 3'd2;
    localparam logic [2:0] FUNC_MULHU  = 3'd3;
    localparam logic [2:0] FUNC_DIV    = 3'd4;
    localparam logic [2:0] FUNC_DIVU   = 3'd5;
    localparam logic [2:0] FUNC_REM    = 3'd6;
    localparam logic [2:0] FUNC_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Callers zero-extend into NEG_W and keep the low WIDTH (or 2*WIDTH) bits,
    // which equals a two's-complement negate at that width.
    localparam int NEG_W = 256;

    function automatic logic [NEG_W-1:0] twos_neg(input logic [NEG_W-1:0] v);
        return ~v + {{(NEG_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational FIX-stage logic: re-applies operand signs to the unsigned
// product/quotient/remainder and selects the half or value func3 asks for.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         func3,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   rem,
    input  logic               sign_a,
    input  logic               sign_b,
    output logic [WIDTH-1:0]   result
);

    logic [NEG_W-1:0]   prod_neg_s;
    logic [NEG_W-1:0]   quo_neg_s;
    logic [NEG_W-1:0]   rem_neg_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic               fix_unused_s;

    // Sign correction and result selection.
    always_comb begin
        prod_neg_s = twos_neg({{(NEG_W-2*WIDTH){1'b0}}, acc});
        quo_neg_s  = twos_neg({{(NEG_W-WIDTH){1'b0}}, acc[WIDTH-1:0]});
        rem_neg_s  = twos_neg({{(NEG_W-WIDTH){1'b0}}, rem});
        // sign_b is already cleared for operands treated as unsigned
        prod_s = (sign_a ^ sign_b) ? prod_neg_s[2*WIDTH-1:0] : acc;
        quo_s  = (sign_a ^ sign_b) ? quo_neg_s[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_s  = sign_a ? rem_neg_s[WIDTH-1:0] : rem;
        case (func3)
            FUNC_MUL:                           result = prod_s[WIDTH-1:0];
            FUNC_MULH, FUNC_MULHSU, FUNC_MULHU: result = prod_s[2*WIDTH-1:WIDTH];
            FUNC_DIV, FUNC_DIVU:                result = quo_s;
            FUNC_REM, FUNC_REMU:                result = rem_s;
            default:                            result = prod_s[WIDTH-1:0];
        endcase
    end

    assign fix_unused_s = ^{prod_neg_s[NEG_W-1:2*WIDTH], quo_neg_s[NEG_W-1:WIDTH],
                            rem_neg_s[NEG_W-1:WIDTH]};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide over WIDTH cycles, with start/result handshakes and kill.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       func3,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             kill,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] aluResult,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_INT   = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [2:0]         func_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opb_r;
    logic [WIDTH-1:0]   rem_r;
    logic               sign_a_r, sign_b_r;
    logic [WIDTH-1:0]   alu_result_r;
    logic               start_ready_r, result_valid_r, busy_r;

    logic               a_signed_s, b_signed_s, sign_a_s, sign_b_s;
    logic [NEG_W-1:0]   neg_a_s, neg_b_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic               div_zero_s, ovf_s, special_s, accept_s;
    logic [WIDTH-1:0]   special_res_s;
    logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   fix_result_s;
    logic               top_unused_s;

    // Operand magnitudes, sign flags and the early-out special cases.
    always_comb begin
        a_signed_s = (func3 == FUNC_MULH) || (func3 == FUNC_MULHSU) ||
                     (func3 == FUNC_DIV)  || (func3 == FUNC_REM);
        b_signed_s = (func3 == FUNC_MULH) || (func3 == FUNC_DIV) || (func3 == FUNC_REM);
        sign_a_s   = a_signed_s & dataA[WIDTH-1];
        sign_b_s   = b_signed_s & dataB[WIDTH-1];
        neg_a_s    = twos_neg({{(NEG_W-WIDTH){1'b0}}, dataA});
        neg_b_s    = twos_neg({{(NEG_W-WIDTH){1'b0}}, dataB});
        mag_a_s    = sign_a_s ? neg_a_s[WIDTH-1:0] : dataA;
        mag_b_s    = sign_b_s ? neg_b_s[WIDTH-1:0] : dataB;
        div_zero_s = func3[2] && (dataB == ZERO_W);
        ovf_s      = ((func3 == FUNC_DIV) || (func3 == FUNC_REM)) &&
                     (dataA == MIN_INT) && (dataB == ONES_W);
        special_s  = div_zero_s | ovf_s;
        // func3[1] separates REM/REMU from DIV/DIVU
        if (div_zero_s) begin
            special_res_s = func3[1] ? dataA : ONES_W;
        end else if (ovf_s) begin
            special_res_s = func3[1] ? ZERO_W : dataA;
        end else begin
            special_res_s = ZERO_W;
        end
        accept_s = (state_r == IDLE) && start_valid && !kill;
    end

    // One shift-add or shift-subtract step.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                      (acc_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {rem_r, acc_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opb_r};
        div_ge_s    = ~div_diff_s[WIDTH];
    end

    // Next-state logic; kill outranks every other transition.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = special_s ? DONE : CALC;
                else          state_s = IDLE;
            end
            CALC: begin
                if (kill)                    state_s = IDLE;
                else if (cnt_r == LAST_ITER) state_s = FIX;
                else                         state_s = CALC;
            end
            FIX: begin
                if (kill) state_s = IDLE;
                else      state_s = DONE;
            end
            DONE: begin
                if (kill || result_ready) state_s = IDLE;
                else                      state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and registered handshake flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            start_ready_r  <= 1'b1;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            start_ready_r  <= (state_s == IDLE);
            result_valid_r <= (state_s == DONE);
            busy_r         <= (state_s != IDLE);
        end
    end

    // Datapath: acc_r low half holds the multiplier or dividend/quotient.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r        <= {CNT_W{1'b0}};
            func_r       <= 3'd0;
            acc_r        <= {(2*WIDTH){1'b0}};
            opb_r        <= ZERO_W;
            rem_r        <= ZERO_W;
            sign_a_r     <= 1'b0;
            sign_b_r     <= 1'b0;
            alu_result_r <= ZERO_W;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        func_r   <= func3;
                        sign_a_r <= sign_a_s;
                        sign_b_r <= sign_b_s;
                        cnt_r    <= {CNT_W{1'b0}};
                        acc_r    <= {ZERO_W, mag_a_s};
                        opb_r    <= mag_b_s;
                        rem_r    <= ZERO_W;
                        if (special_s) alu_result_r <= special_res_s;
                    end
                end
                CALC: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (func_r[2]) begin
                        acc_r <= {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-2:0], div_ge_s};
                        rem_r <= div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
                    end else begin
                        acc_r <= {mul_sum_s, acc_r[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (!kill) alu_result_r <= fix_result_s;
                end
                default: begin
                end
            endcase
        end
    end

    muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .func3  (func_r),
        .acc    (acc_r),
        .rem    (rem_r),
        .sign_a (sign_a_r),
        .sign_b (sign_b_r),
        .result (fix_result_s)
    );

    assign top_unused_s = ^{neg_a_s[NEG_W-1:WIDTH], neg_b_s[NEG_W-1:WIDTH]};

    assign start_ready  = start_ready_r;
    assign result_valid = result_valid_r;
    assign busy         = busy_r;
    assign aluResult    = alu_result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        kill = 1'b0;
    logic        result_ready = 1'b1;
    logic [2:0]  func3 = 3'd0;
    logic [31:0] dataA = 32'd0;
    logic [31:0] dataB = 32'd0;
    logic        start_ready, result_valid, busy;
    logic [31:0] aluResult;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .func3        (func3),
        .dataA        (dataA),
        .dataB        (dataB),
        .kill         (kill),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .aluResult    (aluResult),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op (called #1 after an edge with the unit idle); lat counts
    // edges after the accepting edge until result_valid is seen.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        func3 = f; dataA = a; dataB = b; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        dataA = $urandom; dataB = $urandom; func3 = 3'($urandom);
        lat = 0;
        while (!result_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = aluResult;
        if (result_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] res;
        int          lat;
        logic        seen;

        repeat (2) @(posedge clk);
        #1;
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_aluResult", aluResult, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op(FUNC_MUL, 32'h0000_0007, 32'hFFFF_FFFD, res, lat);
        check("mul_7x-3", res, 32'hFFFF_FFEB);
        check("mul_latency", 32'(lat), 32'd33);
        run_op(FUNC_MULH, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
        check("mulh", res, 32'h0000_0000);
        run_op(FUNC_MULHU, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
        check("mulhu", res, 32'h7FFF_FFFF);
        run_op(FUNC_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
        check("mulhsu", res, 32'h8000_0000);

        run_op(FUNC_DIV, 32'hFFFF_FFF9, 32'h0000_0002, res, lat);
        check("div_-7/2", res, 32'hFFFF_FFFD);
        check("div_latency", 32'(lat), 32'd33);
        run_op(FUNC_REM, 32'hFFFF_FFF9, 32'h0000_0002, res, lat);
        check("rem_-7/2", res, 32'hFFFF_FFFF);
        run_op(FUNC_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, res, lat);
        check("divu", res, 32'h7FFF_FFFC);
        run_op(FUNC_REMU, 32'h0000_0064, 32'h0000_0007, res, lat);
        check("remu_100%7", res, 32'h0000_0002);

        run_op(FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
        check("div_ovf", res, 32'h8000_0000);
        check("div_ovf_latency", 32'(lat), 32'd0);
        run_op(FUNC_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
        check("rem_ovf", res, 32'h0000_0000);
        run_op(FUNC_DIVU, 32'h0000_0005, 32'h0000_0000, res, lat);
        check("divu_by0", res, 32'hFFFF_FFFF);
        check("divu_by0_latency", 32'(lat), 32'd0);
        run_op(FUNC_REMU, 32'h0000_0005, 32'h0000_0000, res, lat);
        check("remu_by0", res, 32'h0000_0005);

        // Back-pressure: result held, new requests ignored while in DONE.
        result_ready = 1'b0;
        run_op(FUNC_DIVU, 32'h0000_0064, 32'h0000_0007, res, lat);
        check("hold_divu", res, 32'h0000_000E);
        func3 = FUNC_MUL; dataA = 32'h1; dataB = 32'h1; start_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_aluResult", aluResult, 32'h0000_000E);
            check("hold_valid", 32'(result_valid), 32'd1);
        end
        check("hold_start_ready", 32'(start_ready), 32'd0);
        result_ready = 1'b1;
        @(posedge clk); #1;
        check("release_start_ready", 32'(start_ready), 32'd1);
        check("release_no_accept", 32'(busy), 32'd0);
        check("release_valid", 32'(result_valid), 32'd0);
        start_valid = 1'b0;

        // kill at CALC iteration 10
        func3 = FUNC_MUL; dataA = 32'd5; dataB = 32'd6; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("calc_busy", 32'(busy), 32'd1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_busy", 32'(busy), 32'd0);
        check("kill_start_ready", 32'(start_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen = seen | result_valid;
        end
        check("kill_no_result", 32'(seen), 32'd0);

        // kill beats start_valid in IDLE
        start_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        check("kill_idle_no_accept", 32'(busy), 32'd0);
        start_valid = 1'b0; kill = 1'b0;

        // Reset mid-CALC
        func3 = FUNC_MUL; dataA = 32'd9; dataB = 32'd9; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_start_ready", 32'(start_ready), 32'd1);
        check("midrst_valid", 32'(result_valid), 32'd0);
        check("midrst_aluResult", aluResult, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_op(FUNC_MUL, 32'd3, 32'd4, res, lat);
        check("mul_3x4_after_rst", res, 32'd12);
        check("mul_3x4_latency", 32'(lat), 32'd33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
